instr_decode_hz: RTL and testbench

Parametrised instruction-decode stage for the pipelined MIPS core. It sits between instruction fetch and execute, and contains:
- the register file, with write-through bypass from WB;
- MEM-to-ID forwarding for branch and jump operands;
- a hazard unit that stalls on load-use and branch-operand dependencies;
- the ID/EX pipeline register, with bubble insertion on stall.

Taken redirects (`beqz`, `bnez`, `jr`, `j`) resolve in ID and flush the IF/ID register.

---
 rtl/instr_decode_hz.sv | 212 +++++++++++++++++++++
 tb/tb_instr_decode_hz.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_hz.sv
// instr_decode_hz: MIPS decode stage -- register file with WB write-through, MEM forwarding,
// load-use/branch hazard unit and ID/EX register. Define ID_PERF_CNT_EN to build stall/flush counters.
module instr_decode_hz #(
    parameter int DW       = 32,
    parameter int RF_DEPTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [63:0]       ifbus,
    input  logic [DW-1:0]     alu_out_mem,
    input  logic [4:0]        write_reg_mem,
    input  logic              reg_write_mem,
    input  logic              mem_to_reg_mem,
    input  logic [4:0]        write_reg_ex,
    input  logic              reg_write_ex,
    input  logic              mem_to_reg_ex,
    input  logic [DW-1:0]     result_wb,
    input  logic [4:0]        write_reg_wb,
    input  logic              reg_write_wb,
    output logic [1:0]        pc_src,
    output logic [31:0]       pc_branch,
    output logic [31:0]       jump_addr,
    output logic              stall_f,
    output logic              flush_f,
    output logic [4:0]        rs_id,
    output logic [4:0]        rt_id,
    output logic [3*DW+22:0]  idbus,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
);
    localparam int         AW    = $clog2(RF_DEPTH);
    localparam logic [5:0] DEPTH = 6'(RF_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQZ = 6'h04, OP_BNEZ = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_SUBI = 6'h0C, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A, F_JR = 6'h08;

    // Packed MSB first, so this is the top byte of idbus.
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic [2:0] alu_ctrl;
        logic       alu_src;
        logic       reg_dst;
    } ctrl_t;

    logic [31:0]   instr, pc4;
    logic [5:0]    op, funct;
    logic [4:0]    rs, rt, rd;
    logic [15:0]   imm;
    logic [DW-1:0] sign_imm;

    assign instr    = ifbus[63:32];
    assign pc4      = ifbus[31:0];
    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign imm      = instr[15:0];
    assign funct    = instr[5:0];
    assign sign_imm = DW'($signed(imm));
    assign rs_id    = rs;
    assign rt_id    = rt;

    ctrl_t      ctrl;
    logic [2:0] alu_r;
    logic       uses_rs, uses_rt, is_beqz, is_bnez, is_jr, is_j;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        ctrl    = '0;
        alu_r   = 3'b000;
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        is_beqz = 1'b0;
        is_bnez = 1'b0;
        is_jr   = 1'b0;
        is_j    = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   alu_r = 3'b001;
                    F_SUB:   alu_r = 3'b010;
                    F_AND:   alu_r = 3'b101;
                    F_OR:    alu_r = 3'b110;
                    F_SLT:   alu_r = 3'b011;
                    F_JR: begin
                        is_jr   = 1'b1;
                        uses_rs = 1'b1;
                    end
                    default: ;
                endcase
                if (alu_r != 3'b000) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                    ctrl.alu_ctrl  = alu_r;
                    uses_rs        = 1'b1;
                    uses_rt        = 1'b1;
                end
            end
            OP_J: is_j = 1'b1;
            OP_BEQZ, OP_BNEZ: begin
                ctrl.alu_ctrl = 3'b010;
                uses_rs       = 1'b1;
                uses_rt       = 1'b1;
                is_beqz       = (op == OP_BEQZ);
                is_bnez       = (op == OP_BNEZ);
            end
            OP_ADDI, OP_SUBI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = (op == OP_ADDI) ? 3'b001 : 3'b010;
                uses_rs        = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_ctrl   = 3'b001;
                uses_rs         = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_ctrl  = 3'b001;
                uses_rs        = 1'b1;
                uses_rt        = 1'b1;
            end
            default: ;
        endcase
    end

    // Register file: r0 and out-of-range indices read 0; a pending WB write is visible to the read.
    logic [DW-1:0] regs [RF_DEPTH];
    logic [DW-1:0] rf_rs, rf_rt, value1, value2;

    function automatic logic in_rf(input logic [4:0] a);
        return (a != 5'd0) && ({1'b0, a} < DEPTH);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the array is reset because the architectural register state must read 0 after reset.
            for (int i = 0; i < RF_DEPTH; i++) regs[i] <= '0;
        end else if (reg_write_wb && in_rf(write_reg_wb)) begin
            regs[write_reg_wb[AW-1:0]] <= result_wb;
        end
    end

    always_comb begin
        rf_rs = '0;
        rf_rt = '0;
        if (in_rf(rs)) rf_rs = (reg_write_wb && write_reg_wb == rs) ? result_wb : regs[rs[AW-1:0]];
        if (in_rf(rt)) rf_rt = (reg_write_wb && write_reg_wb == rt) ? result_wb : regs[rt[AW-1:0]];
    end

    assign value1 = (reg_write_mem && !mem_to_reg_mem && rs != 5'd0 && rs == write_reg_mem) ? alu_out_mem : rf_rs;
    assign value2 = (reg_write_mem && !mem_to_reg_mem && rt != 5'd0 && rt == write_reg_mem) ? alu_out_mem : rf_rt;

    logic ld_use, br_dep, taken_br;

    assign ld_use = mem_to_reg_ex && write_reg_ex != 5'd0 &&
                    ((uses_rs && write_reg_ex == rs) || (uses_rt && write_reg_ex == rt));
    assign br_dep = (is_beqz || is_bnez || is_jr) && rs != 5'd0 &&
                    ((reg_write_ex && write_reg_ex == rs) || (mem_to_reg_mem && write_reg_mem == rs));
    assign stall_f  = ld_use || br_dep;
    assign taken_br = (is_beqz && value1 == '0) || (is_bnez && value1 != '0);

    // A stall suppresses the redirect; it is simply re-evaluated once the operand is ready.
    always_comb begin
        pc_src = 2'b00;
        if (!stall_f) begin
            if (is_j)          pc_src = 2'b11;
            else if (is_jr)    pc_src = 2'b10;
            else if (taken_br) pc_src = 2'b01;
        end
    end

    assign flush_f   = (pc_src != 2'b00);
    assign pc_branch = (32'($signed(imm)) << 2) + pc4;
    assign jump_addr = is_j ? {pc4[31:28], instr[25:0], 2'b00} : 32'(value1);

    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!reset)       idbus <= '0;
        else if (stall_f) idbus <= '0;
        else              idbus <= {ctrl, value1, value2, rs, rt, rd, sign_imm};
    end

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_f && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (flush_f && flush_q != '1) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_decode_hz.sv
// tb_instr_decode_hz: vector table plus hand sequences for hazards, forwarding and reset,
// with expected ID/EX contents queued at drive time and popped after the clock edge.
module tb_instr_decode_hz;
    localparam int DW  = 32;
    localparam int IDW = 3 * DW + 23;

    logic            clock, reset;
    logic [63:0]     ifbus;
    logic [DW-1:0]   alu_out_mem, result_wb;
    logic [4:0]      write_reg_mem, write_reg_ex, write_reg_wb;
    logic            reg_write_mem, mem_to_reg_mem, reg_write_ex, mem_to_reg_ex, reg_write_wb;
    logic [1:0]      pc_src;
    logic [31:0]     pc_branch, jump_addr, stall_cnt, flush_cnt;
    logic            stall_f, flush_f;
    logic [4:0]      rs_id, rt_id;
    logic [IDW-1:0]  idbus;

    instr_decode_hz #(.DW(DW), .RF_DEPTH(16)) dut (
        .clock(clock), .reset(reset), .ifbus(ifbus),
        .alu_out_mem(alu_out_mem), .write_reg_mem(write_reg_mem),
        .reg_write_mem(reg_write_mem), .mem_to_reg_mem(mem_to_reg_mem),
        .write_reg_ex(write_reg_ex), .reg_write_ex(reg_write_ex), .mem_to_reg_ex(mem_to_reg_ex),
        .result_wb(result_wb), .write_reg_wb(write_reg_wb), .reg_write_wb(reg_write_wb),
        .pc_src(pc_src), .pc_branch(pc_branch), .jump_addr(jump_addr),
        .stall_f(stall_f), .flush_f(flush_f), .rs_id(rs_id), .rt_id(rt_id),
        .idbus(idbus), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "timeout");
    end

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [7:0]  ctrl;
        logic [1:0]  src;
    } vec_t;

    typedef struct {
        string          name;
        logic [IDW-1:0] id;
    } sb_t;

    vec_t        vecs[18];
    sb_t         sbq[$];
    logic [31:0] model[16];
    logic [31:0] pc4;
    int          n_checks = 0, n_fail = 0, stall_tot = 0, flush_tot = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [25:0] addr);
        return {6'h02, addr};
    endfunction

    function automatic logic [31:0] rf(input logic [4:0] a);
        if (a == 5'd0 || a >= 5'd16) return 32'd0;
        return model[a[3:0]];
    endfunction

    task automatic wr_model(input logic [4:0] a, input logic [31:0] v);
        if (a != 5'd0 && a < 5'd16) model[a[3:0]] = v;
    endtask

    function automatic logic [IDW-1:0] pack(input logic [7:0] ctrl, input logic [31:0] v1, v2, instr);
        return {ctrl, v1, v2, instr[25:21], instr[20:16], instr[15:11], {{16{instr[15]}}, instr[15:0]}};
    endfunction

    function automatic logic [31:0] cnt_exp(input int tot);
`ifdef ID_PERF_CNT_EN
        return 32'(tot);
`else
        return 32'd0;
`endif
    endfunction

    task automatic idle();
        alu_out_mem = '0; write_reg_mem = '0; reg_write_mem = 0; mem_to_reg_mem = 0;
        write_reg_ex = '0; reg_write_ex = 0; mem_to_reg_ex = 0;
        result_wb = '0; write_reg_wb = '0; reg_write_wb = 0;
    endtask

    task automatic apply(input logic [31:0] instr);
        ifbus = {instr, pc4};
        #2;
    endtask

    task automatic finish_cycle(input string name, input logic [IDW-1:0] exp_id, input bit exp_stall, input bit exp_flush);
        sb_t e;
        sbq.push_back('{name, exp_stall ? '0 : exp_id});
        if (exp_stall) stall_tot++;
        if (exp_flush) flush_tot++;
        @(posedge clock);
        #1;
        e = sbq.pop_front();
        check({e.name, " idbus"}, idbus, e.id);
        check({name, " stall_cnt"}, stall_cnt, cnt_exp(stall_tot));
        check({name, " flush_cnt"}, flush_cnt, cnt_exp(flush_tot));
    endtask

    task automatic step(input string name, input logic [31:0] instr, input logic [IDW-1:0] exp_id,
                        input bit exp_stall, input bit exp_flush, input logic [1:0] exp_src);
        apply(instr);
        check({name, " stall_f"}, stall_f, exp_stall);
        check({name, " flush_f"}, flush_f, exp_flush);
        check({name, " pc_src"}, pc_src, exp_src);
        check({name, " rs_id"}, rs_id, instr[25:21]);
        check({name, " rt_id"}, rt_id, instr[20:16]);
        finish_cycle(name, exp_id, exp_stall, exp_flush);
    endtask

    initial begin
        logic [31:0] ins;

        vecs[0]  = '{"add",    r_type(1, 2, 3, 6'h20),            8'h85, 2'b00};
        vecs[1]  = '{"sub",    r_type(2, 6, 5, 6'h22),            8'h89, 2'b00};
        vecs[2]  = '{"and",    r_type(8, 9, 7, 6'h24),            8'h95, 2'b00};
        vecs[3]  = '{"or",     r_type(10, 11, 12, 6'h25),         8'h99, 2'b00};
        vecs[4]  = '{"slt",    r_type(13, 14, 15, 6'h2A),         8'h8D, 2'b00};
        vecs[5]  = '{"addi",   i_type(6'h08, 1, 3, 16'hFFFC),     8'h86, 2'b00};
        vecs[6]  = '{"subi",   i_type(6'h0C, 4, 5, 16'h0010),     8'h8A, 2'b00};
        vecs[7]  = '{"lw",     i_type(6'h23, 1, 2, 16'h0008),     8'hC6, 2'b00};
        vecs[8]  = '{"sw",     i_type(6'h2B, 5, 4, 16'hFFF8),     8'h26, 2'b00};
        vecs[9]  = '{"beqz_r0", i_type(6'h04, 0, 0, 16'h0003),    8'h08, 2'b01};
        vecs[10] = '{"beqz_r1", i_type(6'h04, 1, 0, 16'h0003),    8'h08, 2'b00};
        vecs[11] = '{"bnez_r1", i_type(6'h05, 1, 0, 16'hFFFF),    8'h08, 2'b01};
        vecs[12] = '{"bnez_r0", i_type(6'h05, 0, 0, 16'h0005),    8'h08, 2'b00};
        vecs[13] = '{"jr",     r_type(9, 0, 0, 6'h08),            8'h00, 2'b10};
        vecs[14] = '{"j",      j_type(26'h0000123),               8'h00, 2'b11};
        vecs[15] = '{"bad_op", i_type(6'h3F, 1, 2, 16'h0007),     8'h00, 2'b00};
        vecs[16] = '{"bad_fn", r_type(1, 2, 3, 6'h21),            8'h00, 2'b00};
        vecs[17] = '{"r20_r21", r_type(20, 21, 1, 6'h20),         8'h85, 2'b00};

        for (int i = 0; i < 16; i++) model[i] = '0;
        idle();
        pc4   = 32'h0000_2000;
        ifbus = '0;
        reset = 1'b0;
        #2;
        check("reset idbus", idbus, '0);
        check("reset stall_cnt", stall_cnt, 32'd0);
        check("reset flush_cnt", flush_cnt, 32'd0);
        @(posedge clock);
        #3 reset = 1'b1;
        @(posedge clock);
        #1;

        // Fill the register file through WB, including r0 and r20 which must stay 0.
        for (int i = 0; i <= 20; i++) begin
            reg_write_wb = 1'b1;
            write_reg_wb = 5'(i);
            result_wb    = 32'h1000 + 32'(i) * 32'h11;
            wr_model(5'(i), result_wb);
            step("preload", 32'h0, '0, 0, 0, 2'b00);
        end
        idle();

        for (int k = 0; k < 18; k++) begin
            ins = vecs[k].instr;
            step(vecs[k].name, ins, pack(vecs[k].ctrl, rf(ins[25:21]), rf(ins[20:16]), ins),
                 0, vecs[k].src != 2'b00, vecs[k].src);
        end

        // Write-through: WB writes r3 in the same cycle ID reads it.
        reg_write_wb = 1; write_reg_wb = 5'd3; result_wb = 32'd5;
        wr_model(5'd3, 32'd5);
        ins = r_type(3, 3, 4, 6'h20);
        step("wb_bypass", ins, pack(8'h85, 32'd5, 32'd5, ins), 0, 0, 2'b00);
        reg_write_wb = 1; write_reg_wb = 5'd0; result_wb = 32'd77;
        ins = r_type(0, 0, 1, 6'h20);
        step("wb_r0", ins, pack(8'h85, 32'd0, 32'd0, ins), 0, 0, 2'b00);
        idle();

        // Load-use on rs: one bubble, then the sub issues.
        mem_to_reg_ex = 1; reg_write_ex = 1; write_reg_ex = 5'd2;
        ins = r_type(2, 6, 5, 6'h22);
        step("lduse_rs", ins, '0, 1, 0, 2'b00);
        idle();
        mem_to_reg_mem = 1; reg_write_mem = 1; write_reg_mem = 5'd2; alu_out_mem = 32'h40;
        step("lduse_issue", ins, pack(8'h89, rf(2), rf(6), ins), 0, 0, 2'b00);
        idle();
        mem_to_reg_ex = 1; reg_write_ex = 1; write_reg_ex = 5'd6;
        step("lduse_rt", ins, '0, 1, 0, 2'b00);
        ins = i_type(6'h08, 2, 6, 16'h0001);
        step("addi_rt_nodep", ins, pack(8'h86, rf(2), rf(6), ins), 0, 0, 2'b00);
        write_reg_ex = 5'd0;
        ins = r_type(0, 0, 3, 6'h20);
        step("lduse_r0", ins, pack(8'h85, 32'd0, 32'd0, ins), 0, 0, 2'b00);
        idle();
        reg_write_ex = 1; write_reg_ex = 5'd2;
        ins = r_type(2, 6, 5, 6'h22);
        step("alu_ex_nodep", ins, pack(8'h89, rf(2), rf(6), ins), 0, 0, 2'b00);
        idle();

        // beqz with its operand forwarded from MEM.
        pc4 = 32'h0000_1000;
        reg_write_mem = 1; write_reg_mem = 5'd7; alu_out_mem = 32'd0;
        ins = i_type(6'h04, 7, 0, 16'h0003);
        apply(ins);
        check("beqz_fwd pc_branch", pc_branch, 32'h0000_100C);
        step("beqz_fwd", ins, pack(8'h08, 32'd0, 32'd0, ins), 0, 1, 2'b01);
        alu_out_mem = 32'd5;
        step("beqz_fwd_nt", ins, pack(8'h08, 32'd5, 32'd0, ins), 0, 0, 2'b00);
        idle();

        // bnez behind an ALU op: stall beats redirect, then taken with the MEM value.
        reg_write_ex = 1; write_reg_ex = 5'd7;
        ins = i_type(6'h05, 7, 0, 16'h0002);
        step("bnez_alu_stall", ins, '0, 1, 0, 2'b00);
        idle();
        reg_write_mem = 1; write_reg_mem = 5'd7; alu_out_mem = 32'h77;
        apply(ins);
        check("bnez_alu pc_branch", pc_branch, 32'h0000_1008);
        step("bnez_alu_taken", ins, pack(8'h08, 32'h77, 32'd0, ins), 0, 1, 2'b01);
        idle();

        // bnez behind lw: two stall cycles, decided by the WB value.
        ins = i_type(6'h05, 8, 0, 16'h0004);
        mem_to_reg_ex = 1; reg_write_ex = 1; write_reg_ex = 5'd8;
        step("bnez_lw_ex", ins, '0, 1, 0, 2'b00);
        idle();
        mem_to_reg_mem = 1; reg_write_mem = 1; write_reg_mem = 5'd8; alu_out_mem = 32'h40;
        step("bnez_lw_mem", ins, '0, 1, 0, 2'b00);
        idle();
        reg_write_wb = 1; write_reg_wb = 5'd8; result_wb = 32'd9;
        wr_model(5'd8, 32'd9);
        step("bnez_lw_taken", ins, pack(8'h08, 32'd9, 32'd0, ins), 0, 1, 2'b01);
        result_wb = 32'd0;
        wr_model(5'd8, 32'd0);
        step("bnez_lw_nt", ins, pack(8'h08, 32'd0, 32'd0, ins), 0, 0, 2'b00);
        idle();

        // jr with rs forwarded from MEM.
        reg_write_mem = 1; write_reg_mem = 5'd9; alu_out_mem = 32'h1234_5678;
        ins = r_type(9, 0, 0, 6'h08);
        apply(ins);
        check("jr jump_addr", jump_addr, 32'h1234_5678);
        step("jr_fwd", ins, pack(8'h00, 32'h1234_5678, 32'd0, ins), 0, 1, 2'b10);
        idle();

        // Asynchronous reset in the middle of a load-use stall.
        ins = r_type(1, 2, 3, 6'h20);
        step("pre_reset", ins, pack(8'h85, rf(1), rf(2), ins), 0, 0, 2'b00);
        mem_to_reg_ex = 1; reg_write_ex = 1; write_reg_ex = 5'd2;
        ins = r_type(2, 6, 5, 6'h22);
        apply(ins);
        check("mid_reset stall_f", stall_f, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("mid_reset idbus", idbus, '0);
        check("mid_reset stall_cnt", stall_cnt, 32'd0);
        check("mid_reset flush_cnt", flush_cnt, 32'd0);
        stall_tot = 0;
        flush_tot = 0;
        for (int i = 0; i < 16; i++) model[i] = '0;
        idle();
        #1 reset = 1'b1;
        #1;
        check("post_reset stall_f", stall_f, 1'b0);
        finish_cycle("post_reset", pack(8'h89, 32'd0, 32'd0, ins), 0, 0);

        // j target and the single flush counted since reset.
        pc4 = 32'h4000_0008;
        ins = j_type(26'h0100040);
        apply(ins);
        check("j jump_addr", jump_addr, 32'h4040_0100);
        step("j", ins, pack(8'h00, 32'd0, 32'd0, ins), 0, 1, 2'b11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
